uart_sram_loader: RTL

Downstream consumer of the UART receive path in the uart2sram design. Takes the receiver's byte strobe and frame-error flag, parses a length-prefixed stream, packs bytes little-endian into 32-bit words and writes them to consecutive SRAM addresses over a req/ack handshake. It reports progress, completion and sticky error status for board-level LEDs or debug.

---
 rtl/uart_sram_loader.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_sram_loader.sv
// uart_sram_loader
// Parses a length-prefixed byte stream from the UART receiver. The first two
// bytes give a word count N (LSB first); the following 4*N bytes are packed
// little-endian into 32-bit words. Each word is written to consecutive SRAM
// word addresses over a req/ack handshake. A one-byte holding register
// absorbs a byte that arrives while a write is waiting for its ack. Error
// flags are sticky until reset.
module uart_sram_loader #(
  parameter int unsigned        ADDR_W    = 18,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_err,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic              sram_ack,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_written,
  output logic              err_frame,
  output logic              err_overrun,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         ww_q, ww_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                err_frame_q, err_frame_d;
  logic                err_overrun_q, err_overrun_d;
  logic                err_timeout_q, err_timeout_d;
  logic [31:0]         tmo_cnt_q, tmo_cnt_d;

  logic                rx_good_s;
  logic                byte_vld_s;
  logic [7:0]          byte_s;
  logic                tmo_run_s;
  logic                tmo_fire_s;
  logic [15:0]         ww_inc_s;

  assign rx_good_s = rx_valid & ~rx_frame_err;
  assign ww_inc_s  = ww_q + 16'd1;

  // Select the byte the FSM sees this cycle (held byte first) and manage the holding register.
  always_comb begin
    byte_vld_s    = 1'b0;
    byte_s        = 8'h00;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    err_overrun_d = err_overrun_q;
    err_frame_d   = err_frame_q;
    if (rx_valid && rx_frame_err) begin
      err_frame_d = 1'b1;
    end else begin
      err_frame_d = err_frame_q;
    end
    if (state_q == ST_WRITE) begin
      // While waiting for ack no byte is consumed; one good byte can be parked.
      if (rx_good_s) begin
        if (hold_full_q) begin
          err_overrun_d = 1'b1;
        end else begin
          hold_d      = rx_data;
          hold_full_d = 1'b1;
        end
      end else begin
        hold_full_d = hold_full_q;
      end
    end else begin
      if (hold_full_q) begin
        // Drain the parked byte; a byte arriving now takes its place.
        byte_vld_s = 1'b1;
        byte_s     = hold_q;
        if (rx_good_s) begin
          hold_d = rx_data;
        end else begin
          hold_full_d = 1'b0;
        end
      end else begin
        byte_vld_s = rx_good_s;
        byte_s     = rx_data;
      end
    end
  end

  // Inter-byte timeout: counts idle cycles only while a header or word is partially received.
  always_comb begin
    tmo_run_s  = (TIMEOUT != 32'd0) && ((state_q == ST_HDR1) || (state_q == ST_DATA));
    tmo_fire_s = 1'b0;
    tmo_cnt_d  = 32'd0;
    if (tmo_run_s && !rx_valid && !hold_full_q) begin
      if (tmo_cnt_q == (TIMEOUT - 32'd1)) begin
        tmo_fire_s = 1'b1;
        tmo_cnt_d  = 32'd0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
    end else begin
      tmo_cnt_d = 32'd0;
    end
  end

  // Next-state and datapath updates of the stream parser / write FSM.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    lane_d        = lane_q;
    word_d        = word_q;
    addr_d        = addr_q;
    req_d         = req_q;
    done_d        = done_q;
    ww_d          = ww_q;
    err_timeout_d = err_timeout_q;
    busy_d        = 1'b0;
    case (state_q)
      ST_HDR0: begin
        if (byte_vld_s) begin
          len_d[7:0] = byte_s;
          state_d    = ST_HDR1;
        end else begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR1: begin
        if (tmo_fire_s) begin
          err_timeout_d = 1'b1;
          state_d       = ST_HDR0;
        end else if (byte_vld_s) begin
          len_d[15:8] = byte_s;
          ww_d        = 16'd0;
          if ({byte_s, len_q[7:0]} == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = BASE_ADDR;
            lane_d  = 2'd0;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_HDR1;
        end
      end
      ST_DATA: begin
        if (tmo_fire_s) begin
          err_timeout_d = 1'b1;
          lane_d        = 2'd0;
          state_d       = ST_HDR0;
        end else if (byte_vld_s) begin
          word_d[{lane_q, 3'b000} +: 8] = byte_s;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            req_d   = 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (sram_ack) begin
          req_d  = 1'b0;
          ww_d   = ww_inc_s;
          addr_d = addr_q + ADDR_ONE;
          if (ww_inc_s == len_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (byte_vld_s) begin
          done_d     = 1'b0;
          len_d[7:0] = byte_s;
          state_d    = ST_HDR1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_HDR0;
        req_d   = 1'b0;
        lane_d  = 2'd0;
      end
    endcase
    if ((state_d == ST_HDR1) || (state_d == ST_DATA) || (state_d == ST_WRITE)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and output registers; asynchronous reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HDR0;
      len_q         <= 16'd0;
      lane_q        <= 2'd0;
      word_q        <= 32'd0;
      addr_q        <= BASE_ADDR;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ww_q          <= 16'd0;
      hold_q        <= 8'h00;
      hold_full_q   <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
      tmo_cnt_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      lane_q        <= lane_d;
      word_q        <= word_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ww_q          <= ww_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign sram_req      = req_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = word_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = ww_q;
  assign err_frame     = err_frame_q;
  assign err_overrun   = err_overrun_q;
  assign err_timeout   = err_timeout_q;

endmodule
